// File: rtl/manchester_pkg.sv
// Shared types and constants for the Manchester transmit serializer.
// Line coding follows IEEE 802.3: a '1' is low-then-high, a '0' is high-then-low.
package manchester_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StPreamble,
    StData,
    StStop
  } tx_state_e;

  localparam logic MANCH_ONE_FIRST_HALF  = 1'b0;
  localparam logic MANCH_ZERO_FIRST_HALF = 1'b1;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/manchester_tx_serializer_tick.sv
// Half-bit timebase: tick is high on the last cycle of every HALF_BIT_DIV-cycle half-bit.
// clr holds the count at zero so the first half-bit after a restart is full length.
module halfbit_tick_gen #(
  parameter int unsigned HALF_BIT_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CntW = $clog2(HALF_BIT_DIV) + 1;
  localparam logic [CntW-1:0] CntMax = CntW'(HALF_BIT_DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr || (cnt_q == CntMax)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == CntMax);

endmodule

// File: rtl/manchester_tx_serializer.sv
// Frames each accepted word as preamble, MSB-first data, even parity and a stop marker,
// and drives it Manchester-coded on tx_out.
module manchester_tx_serializer
  import manchester_pkg::*;
#(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned HALF_BIT_DIV = 4,
  parameter int unsigned PREAMBLE_LEN = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              tx_out,
  output logic              tx_en,
  output logic              busy,
  output logic              frame_done
);

  localparam int unsigned BitCntW = $clog2(max_u(PREAMBLE_LEN, DATA_W + 1));
  localparam logic [BitCntW-1:0] PreLast  = BitCntW'(PREAMBLE_LEN - 1);
  localparam logic [BitCntW-1:0] DataLast = BitCntW'(DATA_W);

  tx_state_e           state_q, state_d;
  logic                phase_q, phase_d;
  logic [BitCntW-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic                parity_q, parity_d;
  logic                tx_out_q, tx_out_d;
  logic                tx_en_q, tx_en_d;
  logic                line_bit;
  logic                tick;

  // Idle holds the timebase cleared, so accept always starts a fresh half-bit.
  halfbit_tick_gen #(
    .HALF_BIT_DIV(HALF_BIT_DIV)
  ) u_tick (
    .clk (clk),
    .rst (rst),
    .clr (state_q == StIdle),
    .tick(tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      phase_q   <= 1'b0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      parity_q  <= 1'b0;
      tx_out_q  <= 1'b0;
      tx_en_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      parity_q  <= parity_d;
      tx_out_q  <= tx_out_d;
      tx_en_q   <= tx_en_d;
    end
  end

  // phase_q: 0 = first half of the current bit, 1 = second half.
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          state_d   = StPreamble;
          phase_d   = 1'b0;
          bit_cnt_d = '0;
          shift_d   = in_data;
          parity_d  = ^in_data;
        end
      end
      StPreamble: begin
        if (tick) begin
          phase_d = ~phase_q;
          if (phase_q) begin
            if (bit_cnt_q == PreLast) begin
              state_d   = StData;
              bit_cnt_d = '0;
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end
        end
      end
      StData: begin
        if (tick) begin
          phase_d = ~phase_q;
          if (phase_q) begin
            if (bit_cnt_q == DataLast) begin
              state_d   = StStop;
              bit_cnt_d = '0;
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
              shift_d   = shift_q << 1;
            end
          end
        end
      end
      StStop: begin
        if (tick) begin
          phase_d = ~phase_q;
          if (phase_q) begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Line level is computed from next-state values so tx_out leaves a flop.
  always_comb begin
    line_bit = 1'b0;
    case (state_d)
      StPreamble: line_bit = ~bit_cnt_d[0];
      StData:     line_bit = (bit_cnt_d == DataLast) ? parity_d : shift_d[DATA_W-1];
      default:    line_bit = 1'b0;
    endcase
    tx_en_d  = (state_d != StIdle);
    tx_out_d = 1'b0;
    if ((state_d == StPreamble) || (state_d == StData)) begin
      if (phase_d) begin
        tx_out_d = line_bit;
      end else begin
        tx_out_d = line_bit ? MANCH_ONE_FIRST_HALF : MANCH_ZERO_FIRST_HALF;
      end
    end
  end

  assign tx_out     = tx_out_q;
  assign tx_en      = tx_en_q;
  assign in_ready   = (state_q == StIdle);
  assign busy       = (state_q != StIdle);
  // Decoded purely from flops: last half-bit of the stop marker.
  assign frame_done = (state_q == StStop) && phase_q && tick;

endmodule

// File: tb/tb_manchester_tx_serializer.sv
// Scoreboard bench: accepted words are queued with their accept cycle, and a monitor
// compares every frame cycle against a level model built from the frame rules.
module tb_manchester_tx_serializer;

  localparam int DW        = 8;
  localparam int DIV       = 4;
  localparam int PRE       = 8;
  localparam int FrameLen  = (PRE + DW + 2) * 2 * DIV;
  localparam int DW2       = 4;
  localparam int DIV2      = 1;
  localparam int FrameLen2 = (PRE + DW2 + 2) * 2 * DIV2;

  logic           clk = 1'b0;
  logic           rst;
  logic [DW-1:0]  in_data;
  logic           in_valid;
  logic           in_ready, tx_out, tx_en, busy, frame_done;
  logic [DW2-1:0] in_data2;
  logic           in_valid2;
  logic           in_ready2, tx_out2, tx_en2, busy2, frame_done2;

  always #5 clk = ~clk;

  manchester_tx_serializer #(
    .DATA_W(DW), .HALF_BIT_DIV(DIV), .PREAMBLE_LEN(PRE)
  ) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .tx_out(tx_out), .tx_en(tx_en), .busy(busy), .frame_done(frame_done)
  );

  manchester_tx_serializer #(
    .DATA_W(DW2), .HALF_BIT_DIV(DIV2), .PREAMBLE_LEN(PRE)
  ) dut2 (
    .clk(clk), .rst(rst), .in_data(in_data2), .in_valid(in_valid2), .in_ready(in_ready2),
    .tx_out(tx_out2), .tx_en(tx_en2), .busy(busy2), .frame_done(frame_done2)
  );

  typedef struct {
    int data;
    int start;
  } exp_t;

  exp_t exp_q[$];
  exp_t e_new;
  exp_t cur;
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  logic rst_prev = 1'b0;
  logic rdy_s = 1'b0;
  logic rdy2_s = 1'b0;
  logic acc_flag = 1'b0;
  logic acc2_flag = 1'b0;
  int   acc_cyc = 0;
  bit   cap = 1'b0;
  int   idx = 0;

  task automatic chk(input string name, input int act, input int req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0d, want %0d", name, cyc, act, req);
    end
  endtask

  // Line level at cycle idx of a frame, straight from the frame rules.
  function automatic int model_level(input int data, input int dw, input int div, input int i);
    int hb;
    int b;
    int bitv;
    hb = i / div;
    b  = hb / 2;
    if (b < PRE) bitv = (b % 2 == 0) ? 1 : 0;
    else if (b < PRE + dw) bitv = (data >> (dw - 1 - (b - PRE))) & 1;
    else if (b == PRE + dw) bitv = $countones(data) % 2;
    else return 0;
    return (hb % 2 == 1) ? bitv : 1 - bitv;
  endfunction

  // Handshake detection: in_ready is sampled on the negedge before the edge.
  always @(posedge clk) begin
    cyc++;
    rst_prev = rst;
    acc_flag = !rst && in_valid && rdy_s;
    if (acc_flag) begin
      e_new.data  = int'(in_data);
      e_new.start = cyc;
      exp_q.push_back(e_new);
      acc_cyc = cyc;
    end
    acc2_flag = !rst && in_valid2 && rdy2_s;
  end

  always @(negedge clk) begin
    rdy_s  = in_ready;
    rdy2_s = in_ready2;
    if (rst_prev) begin
      chk("rst_tx_en", int'(tx_en), 0);
      chk("rst_tx_out", int'(tx_out), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_in_ready", int'(in_ready), 1);
      chk("rst_frame_done", int'(frame_done), 0);
      cap = 1'b0;
      exp_q.delete();
    end else begin
      if (!cap && exp_q.size() > 0 && cyc >= exp_q[0].start) begin
        cur = exp_q.pop_front();
        chk("frame_start", cyc, cur.start);
        cap = 1'b1;
        idx = 0;
      end
      if (cap) begin
        chk("tx_out", int'(tx_out), model_level(cur.data, DW, DIV, idx));
        chk("tx_en", int'(tx_en), 1);
        chk("in_ready", int'(in_ready), 0);
        chk("busy", int'(busy), 1);
        chk("frame_done", int'(frame_done), (idx == FrameLen - 1) ? 1 : 0);
        idx++;
        if (idx == FrameLen) cap = 1'b0;
      end else begin
        chk("idle_tx_en", int'(tx_en), 0);
        chk("idle_tx_out", int'(tx_out), 0);
        chk("idle_in_ready", int'(in_ready), 1);
        chk("idle_busy", int'(busy), 0);
        chk("idle_frame_done", int'(frame_done), 0);
      end
    end
  end

  task automatic wait_acc(output int at);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!acc_flag && n < 1000);
    if (!acc_flag) chk("accept_timeout", 0, 1);
    at = acc_cyc;
  endtask

  task automatic send(input logic [DW-1:0] d);
    int at;
    in_valid = 1'b1;
    in_data  = d;
    wait_acc(at);
    in_valid = 1'b0;
    in_data  = DW'($urandom);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((cap || exp_q.size() > 0 || !in_ready) && n < 1000);
    if (n >= 1000) chk("idle_timeout", 0, 1);
  endtask

  initial begin
    int a1;
    int a2;
    int n;
    rst       = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'h77;
    in_valid2 = 1'b0;
    in_data2  = '0;
    repeat (3) @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;

    send(8'hA5);
    wait_idle();
    send(8'h01);
    wait_idle();
    send(8'h00);
    wait_idle();
    send(8'hFF);
    wait_idle();

    // Back-to-back with in_valid held high throughout.
    in_valid = 1'b1;
    in_data  = 8'h3C;
    wait_acc(a1);
    in_data = 8'hC3;
    wait_acc(a2);
    in_valid = 1'b0;
    chk("b2b_gap", a2 - a1, FrameLen + 1);
    wait_idle();

    // Reset around cycle 50 of a frame, then a clean frame.
    send(8'h66);
    repeat (49) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    send(8'h5A);
    wait_idle();

    // Random traffic; data changes while busy must be ignored.
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #1;
      in_valid = ($urandom_range(0, 3) != 0);
      in_data  = DW'($urandom);
      rst      = ($urandom_range(0, 999) == 0);
    end
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    wait_idle();

    // Fast instance: one clock per half-bit, 4-bit word.
    in_valid2 = 1'b1;
    in_data2  = 4'h9;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!acc2_flag && n < 100);
    if (!acc2_flag) chk("accept2_timeout", 0, 1);
    in_valid2 = 1'b0;
    for (int i = 0; i < FrameLen2; i++) begin
      @(negedge clk);
      chk("tx_out2", int'(tx_out2), model_level(9, DW2, DIV2, i));
      chk("tx_en2", int'(tx_en2), 1);
      chk("in_ready2", int'(in_ready2), 0);
      chk("frame_done2", int'(frame_done2), (i == FrameLen2 - 1) ? 1 : 0);
    end
    @(negedge clk);
    chk("tx_en2_end", int'(tx_en2), 0);
    chk("in_ready2_end", int'(in_ready2), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
